// File: rtl/nvdla_attn_rd_sched.sv
// nvdla_attn_rd_sched: round-robin Q/K/V/Mask read-request scheduler with credit-limited issue
module nvdla_attn_rd_sched #(
    parameter int ADDR_W          = 32,
    parameter int BEAT_BYTES      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seq_length,
    input  logic              mask_enable,
    input  logic [ADDR_W-1:0] q_base,
    input  logic [ADDR_W-1:0] k_base,
    input  logic [ADDR_W-1:0] v_base,
    input  logic [ADDR_W-1:0] m_base,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [ADDR_W-1:0] rd_req_addr,
    output logic [1:0]        rd_req_id,
    input  logic              rd_rsp_valid,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err,
    output logic [3:0]        outstanding
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [31:0]       seq_len;
    logic              mask_en;
    logic [ADDR_W-1:0] acc [4];
    logic [31:0]       iss [4];
    logic [1:0]        last_grant, gnt;
    logic              gnt_any, abort_seen, abort_hit, can_arb, credit_ok, load, all_issued;
    logic [3:0]        left, elig;

    assign busy      = state != IDLE;
    assign abort_hit = abort_seen | (abort & (state == ISSUE));
    assign can_arb   = !rd_req_valid || rd_req_ready;
    assign credit_ok = outstanding < 4'(MAX_OUTSTANDING);
    assign load      = can_arb && gnt_any;
    assign all_issued = ~|left;

    // Per-stream eligibility: enabled, beats remaining, issuing, not aborted, credit available
    always_comb begin
        left = '0;
        elig = '0;
        for (int s = 0; s < 4; s++) begin
            left[s] = (s != 3 || mask_en) && iss[s] < seq_len;
            elig[s] = left[s] && state == ISSUE && !abort_hit && credit_ok;
        end
    end

    // Round-robin pick starting one past the last granted stream
    always_comb begin
        logic [1:0] c;
        gnt_any = 1'b0;
        gnt     = last_grant;
        c       = last_grant;
        for (int i = 1; i < 5; i++) begin
            c = last_grant + 2'(i);
            if (!gnt_any && elig[c]) begin
                gnt_any = 1'b1;
                gnt     = c;
            end
        end
    end

    // Next-state logic; a pending request must hand off before leaving ISSUE
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (seq_length == 32'd0 ? DONE : ISSUE) : IDLE;
            ISSUE:   state_n = ((all_issued || abort_hit) && can_arb) ? DRAIN : ISSUE;
            DRAIN:   state_n = outstanding == 4'd0 ? DONE : DRAIN;
            default: state_n = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Captured config plus per-stream beat counters and address accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_len    <= '0;
            mask_en    <= 1'b0;
            last_grant <= 2'd3;
            for (int s = 0; s < 4; s++) begin
                acc[s] <= '0;
                iss[s] <= '0;
            end
        end else if (state == IDLE && start) begin
            seq_len    <= seq_length;
            mask_en    <= mask_enable;
            last_grant <= 2'd3;
            acc[0]     <= q_base;
            acc[1]     <= k_base;
            acc[2]     <= v_base;
            acc[3]     <= m_base;
            for (int s = 0; s < 4; s++) iss[s] <= '0;
        end else if (load) begin
            last_grant <= gnt;
            acc[gnt]   <= acc[gnt] + ADDR_W'(BEAT_BYTES);
            iss[gnt]   <= iss[gnt] + 32'd1;
        end
    end

    // Request register: holds steady until accepted, reloads on the same cycle as a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            rd_req_id    <= '0;
        end else if (load) begin
            rd_req_valid <= 1'b1;
            rd_req_addr  <= acc[gnt];
            rd_req_id    <= gnt;
        end else if (rd_req_ready) begin
            rd_req_valid <= 1'b0;
        end
    end

    // Credits reserved at load and returned by responses; underflow latches err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (load && !rd_rsp_valid) outstanding <= outstanding + 4'd1;
            else if (!load && rd_rsp_valid && outstanding != 4'd0) outstanding <= outstanding - 4'd1;
            if (rd_rsp_valid && outstanding == 4'd0) err <= 1'b1;
        end
    end

    // Abort tracking and the completion pulse that follows the DONE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_seen <= 1'b0;
            aborted    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= state == DONE;
            if (state == IDLE) abort_seen <= 1'b0;
            else if (abort && (state == ISSUE || state == DRAIN)) abort_seen <= 1'b1;
            if (state == IDLE && start) aborted <= 1'b0;
            else if (state == DONE && abort_seen) aborted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_nvdla_attn_rd_sched.sv
// tb_nvdla_attn_rd_sched: scenario tasks checked against a stream-order/address reference model
module tb_nvdla_attn_rd_sched;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, mask_enable = 0;
    logic        rd_req_ready = 0, rd_rsp_valid = 0;
    logic [31:0] seq_length = 0, q_base = 0, k_base = 0, v_base = 0, m_base = 0;
    logic        rd_req_valid, busy, done, aborted, err;
    logic [31:0] rd_req_addr;
    logic [1:0]  rd_req_id;
    logic [3:0]  outstanding;
    int          vec = 0, mis = 0;

    nvdla_attn_rd_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_length(seq_length),
        .mask_enable(mask_enable), .q_base(q_base), .k_base(k_base), .v_base(v_base),
        .m_base(m_base), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_req_addr(rd_req_addr), .rd_req_id(rd_req_id), .rd_rsp_valid(rd_rsp_valid),
        .busy(busy), .done(done), .aborted(aborted), .err(err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; abort = 0; rd_req_ready = 0; rd_rsp_valid = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic launch(input logic [31:0] seq, input logic msk,
                          input logic [31:0] qb, input logic [31:0] kb,
                          input logic [31:0] vb, input logic [31:0] mb);
        tick();
        start = 1; seq_length = seq; mask_enable = msk;
        q_base = qb; k_base = kb; v_base = vb; m_base = mb;
        tick();
        start = 0;
    endtask

    // Full load: requests must come out as Q,K,V(,M) per beat at base+beat*16
    task automatic run_load(input logic [31:0] seq, input logic msk,
                            input logic [31:0] qb, input logic [31:0] kb,
                            input logic [31:0] vb, input logic [31:0] mb,
                            input bit rnd, input int dly, input string tag);
        logic [33:0] exp_q[$];
        int          due[$];
        logic [31:0] bs[4];
        logic [33:0] e;
        int          cyc, done_cyc, last_rsp;
        bit          got;
        bs[0] = qb; bs[1] = kb; bs[2] = vb; bs[3] = mb;
        for (int b = 0; b < int'(seq); b++)
            for (int s = 0; s < 4; s++)
                if (s < 3 || msk) exp_q.push_back({2'(s), bs[s] + 32'(b * 16)});
        rd_req_ready = 1;
        launch(seq, msk, qb, kb, vb, mb);
        smp();
        vec++;
        if (rd_req_valid !== 1'b0 || busy !== 1'b1) begin
            mis++;
            $display("FAIL %s_c1: valid=%b busy=%b want valid=0 busy=1", tag, rd_req_valid, busy);
        end
        cyc = 0; got = 0; done_cyc = -1; last_rsp = -1;
        while (!got && cyc < 600) begin
            tick();
            rd_req_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rd_rsp_valid = 0;
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                rd_rsp_valid = 1;
                last_rsp = cyc;
            end
            smp();
            if (cyc == 0) begin
                vec++;
                if (rd_req_valid !== (seq != 0)) begin
                    mis++;
                    $display("FAIL %s_first_valid: valid=%b want %b", tag, rd_req_valid, seq != 0);
                end
            end
            if (rd_req_valid && rd_req_ready) begin
                vec++;
                if (exp_q.size() == 0) begin
                    mis++;
                    $display("FAIL %s_extra_req: id=%0d addr=%h want no request", tag, rd_req_id, rd_req_addr);
                end else begin
                    e = exp_q.pop_front();
                    if ({rd_req_id, rd_req_addr} !== e) begin
                        mis++;
                        $display("FAIL %s_req: id=%0d addr=%h want id=%0d addr=%h", tag, rd_req_id, rd_req_addr, e[33:32], e[31:0]);
                    end
                end
                due.push_back(cyc + (dly > 0 ? dly : int'($urandom_range(1, 5))));
            end
            if (done) begin
                got = 1;
                done_cyc = cyc;
            end
            cyc++;
        end
        vec++;
        if (!got || exp_q.size() != 0 || due.size() != 0) begin
            mis++;
            $display("FAIL %s_complete: done=%0b left_reqs=%0d left_rsps=%0d want 1/0/0", tag, got, exp_q.size(), due.size());
        end
        vec++;
        if (seq == 0 ? done_cyc != 0 : done_cyc <= last_rsp) begin
            mis++;
            $display("FAIL %s_done_time: done_cyc=%0d last_rsp=%0d", tag, done_cyc, last_rsp);
        end
        vec++;
        if (err !== 1'b0 || aborted !== 1'b0) begin
            mis++;
            $display("FAIL %s_flags: err=%b aborted=%b want 0 0", tag, err, aborted);
        end
        tick();
        rd_rsp_valid = 0;
        smp();
        vec++;
        if (done !== 1'b0 || busy !== 1'b0 || outstanding !== 4'd0) begin
            mis++;
            $display("FAIL %s_after: done=%b busy=%b outstanding=%0d want 0 0 0", tag, done, busy, outstanding);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        smp();
        vec++;
        if ({rd_req_valid, rd_req_addr, rd_req_id, busy, done, aborted, err, outstanding} !== '0) begin
            mis++;
            $display("FAIL reset: valid=%b addr=%h id=%0d busy=%b done=%b ab=%b err=%b out=%0d want all 0",
                     rd_req_valid, rd_req_addr, rd_req_id, busy, done, aborted, err, outstanding);
        end
        do_reset();
    endtask

    task automatic test_basic();
        run_load(2, 0, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 0, 3, "basic");
    endtask

    task automatic test_credit();
        int n;
        do_reset();
        rd_req_ready = 1;
        launch(4, 1, 32'h100, 32'h200, 32'h300, 32'h400);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            smp();
            if (rd_req_valid && rd_req_ready) n++;
        end
        vec++;
        if (n != 8 || rd_req_valid !== 1'b0 || outstanding !== 4'd8) begin
            mis++;
            $display("FAIL credit_cap: reqs=%0d valid=%b out=%0d want 8 0 8", n, rd_req_valid, outstanding);
        end
        tick();
        rd_rsp_valid = 1;
        smp();
        if (rd_req_valid && rd_req_ready) n++;
        for (int i = 0; i < 10; i++) begin
            tick();
            rd_rsp_valid = 0;
            smp();
            if (rd_req_valid && rd_req_ready) n++;
        end
        vec++;
        if (n != 9 || outstanding !== 4'd8) begin
            mis++;
            $display("FAIL credit_refill: reqs=%0d out=%0d want 9 8", n, outstanding);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [1:0]  d;
        do_reset();
        launch(2, 0, 32'h100, 32'h200, 32'h300, 32'h0);
        tick();
        smp();
        a = rd_req_addr;
        d = rd_req_id;
        vec++;
        if (rd_req_valid !== 1'b1 || d !== 2'd0 || a !== 32'h100) begin
            mis++;
            $display("FAIL stall_first: valid=%b id=%0d addr=%h want 1 0 00000100", rd_req_valid, d, a);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            smp();
            vec++;
            if (rd_req_valid !== 1'b1 || rd_req_id !== d || rd_req_addr !== a) begin
                mis++;
                $display("FAIL stall_hold: valid=%b id=%0d addr=%h want 1 %0d %h", rd_req_valid, rd_req_id, rd_req_addr, d, a);
            end
        end
        tick();
        rd_req_ready = 1;
        tick();
        rd_req_ready = 0;
        smp();
        vec++;
        if (rd_req_valid !== 1'b1 || rd_req_id !== 2'd1 || rd_req_addr !== 32'h200) begin
            mis++;
            $display("FAIL stall_next: valid=%b id=%0d addr=%h want 1 1 00000200", rd_req_valid, rd_req_id, rd_req_addr);
        end
    endtask

    task automatic test_zero_and_wrap();
        do_reset();
        run_load(0, 1, 32'h10, 32'h20, 32'h30, 32'h40, 0, 2, "zero");
        run_load(2, 0, 32'hFFFFFFF0, 32'h2000, 32'h3000, 32'h0, 0, 2, "wrap");
    endtask

    task automatic test_abort();
        int  n, g;
        bit  got;
        do_reset();
        rd_req_ready = 1;
        launch(4, 0, 32'h1000, 32'h2000, 32'h3000, 32'h0);
        n = 0; g = 0;
        while (n < 3 && g < 20) begin
            tick();
            smp();
            if (rd_req_valid && rd_req_ready) n++;
            g++;
        end
        tick();
        rd_req_ready = 0;
        abort = 1;
        smp();
        vec++;
        if (rd_req_valid !== 1'b1 || outstanding !== 4'd4) begin
            mis++;
            $display("FAIL abort_pending: valid=%b out=%0d want 1 4", rd_req_valid, outstanding);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            abort = 0;
            rd_req_ready = 1;
            smp();
            if (rd_req_valid && rd_req_ready) n++;
        end
        vec++;
        if (n != 1 || busy !== 1'b1 || done !== 1'b0) begin
            mis++;
            $display("FAIL abort_drain: reqs=%0d busy=%b done=%b want 1 1 0", n, busy, done);
        end
        got = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            rd_rsp_valid = 1;
            smp();
            if (done) got = 1;
            tick();
            rd_rsp_valid = 0;
            smp();
            if (done && !got) begin
                got = 1;
                vec++;
                if (k != 3 || aborted !== 1'b1) begin
                    mis++;
                    $display("FAIL abort_done: after_rsp=%0d aborted=%b want 4 1", k + 1, aborted);
                end
            end
        end
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            smp();
            if (done) begin
                got = 1;
                vec++;
                if (aborted !== 1'b1) begin
                    mis++;
                    $display("FAIL abort_done: aborted=%b want 1", aborted);
                end
            end
        end
        vec++;
        if (!got || err !== 1'b0) begin
            mis++;
            $display("FAIL abort_finish: done_seen=%0b err=%b want 1 0", got, err);
        end
        launch(1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        smp();
        vec++;
        if (aborted !== 1'b0) begin
            mis++;
            $display("FAIL abort_clear: aborted=%b want 0", aborted);
        end
    endtask

    task automatic test_err_and_async_reset();
        do_reset();
        tick();
        rd_rsp_valid = 1;
        tick();
        rd_rsp_valid = 0;
        smp();
        vec++;
        if (err !== 1'b1 || outstanding !== 4'd0) begin
            mis++;
            $display("FAIL err_set: err=%b out=%0d want 1 0", err, outstanding);
        end
        rd_req_ready = 1;
        launch(4, 1, 32'h100, 32'h200, 32'h300, 32'h400);
        tick();
        smp();
        vec++;
        if (err !== 1'b1 || busy !== 1'b1 || rd_req_valid !== 1'b1) begin
            mis++;
            $display("FAIL err_sticky: err=%b busy=%b valid=%b want 1 1 1", err, busy, rd_req_valid);
        end
        #1 rst_n = 0;
        #1;
        vec++;
        if ({rd_req_valid, rd_req_addr, rd_req_id, busy, done, aborted, err, outstanding} !== '0) begin
            mis++;
            $display("FAIL async_reset: valid=%b addr=%h id=%0d busy=%b err=%b out=%0d want all 0",
                     rd_req_valid, rd_req_addr, rd_req_id, busy, err, outstanding);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++)
            run_load($urandom_range(1, 6), 1'($urandom_range(0, 1)),
                     $urandom & 32'hFFFFFFF0, $urandom, 32'hFFFFFFE0, $urandom & 32'hFFFFFF00,
                     1, 0, "rand");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_credit();
        test_stall();
        test_zero_and_wrap();
        test_abort();
        test_err_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
